// File: rtl/counter_ctrl.sv
// Start/pause/clear controller for a decimal counter: synchronizes and debounces two
// pushbuttons, runs an IDLE/RUN/PAUSE FSM and prescales clk1k into one-cycle count enables.
module counter_ctrl #(
    parameter int DEBOUNCE = 20,
    parameter int TICK_DIV = 1000
) (
    input  logic       clk1k,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic       cnt_en,
    output logic       cnt_rst,
    output logic [1:0] state,
    output logic       run_led
);

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_e;

    // Index 0 is the start button, index 1 the clear button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    db_q, db_d;
    logic [1:0]    press;
    logic [DW-1:0] dbcnt_q [2];
    logic [DW-1:0] dbcnt_d [2];

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_rst_q, cnt_rst_d;
    logic          run_led_q, run_led_d;
    logic          start_ev, clear_ev;

    assign btn_raw = {btn_clear, btn_start};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]    = db_q[i];
            dbcnt_d[i] = '0;
            // The level flips on the DEBOUNCE-th consecutive disagreeing sample.
            if (sync2_q[i] != db_q[i]) begin
                if (dbcnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dbcnt_d[i] = dbcnt_q[i] + DW'(1);
                end
            end
            press[i] = db_d[i] & ~db_q[i];
        end
    end

    assign start_ev = press[0];
    assign clear_ev = press[1];

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_en_d  = 1'b0;
        cnt_rst_d = 1'b0;

        case (state_q)
            IDLE: begin
                pre_d = '0;
                if (start_ev) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The tick still fires if the pause lands on the last prescaler cycle.
                if (pre_q == PRE_LAST) begin
                    pre_d    = '0;
                    cnt_en_d = 1'b1;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
                if (start_ev) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (start_ev) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                pre_d   = '0;
            end
        endcase

        // Clear overrides everything, including a simultaneous start or a due tick.
        if (clear_ev) begin
            state_d   = IDLE;
            pre_d     = '0;
            cnt_en_d  = 1'b0;
            cnt_rst_d = 1'b1;
        end

        run_led_d = (state_d == RUN);
    end

    always_ff @(posedge clk1k) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                dbcnt_q[i] <= '0;
            end
            state_q   <= IDLE;
            pre_q     <= '0;
            cnt_en_q  <= 1'b0;
            cnt_rst_q <= 1'b1;
            run_led_q <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            for (int i = 0; i < 2; i++) begin
                dbcnt_q[i] <= dbcnt_d[i];
            end
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_en_q  <= cnt_en_d;
            cnt_rst_q <= cnt_rst_d;
            run_led_q <= run_led_d;
        end
    end

    assign state   = state_q;
    assign cnt_en  = cnt_en_q;
    assign cnt_rst = cnt_rst_q;
    assign run_led = run_led_q;

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The module SHALL have parameter DEBOUNCE, default 20, giving the number of clk1k cycles a button level must hold before it is accepted (20 ms at 1 kHz).
REQ-002 The module SHALL have parameter TICK_DIV, default 1000, giving the number of clk1k cycles per count tick (1 Hz at 1 kHz).
REQ-003 Port clk1k  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port btn_start  input  1  raw asynchronous start/pause pushbutton, active-high.
REQ-006 Port btn_clear  input  1  raw asynchronous clear pushbutton, active-high.
REQ-007 Port cnt_en  output  1  one-cycle enable pulse to the decimal counter, issued once per tick.
REQ-008 Port cnt_rst  output  1  one-cycle synchronous clear pulse to the decimal counter.
REQ-009 Port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
REQ-010 Port run_led  output  1  high exactly when state is RUN.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Debounce: debounced level SHALL take the synchronized level only after that level has differed from the current debounced level for DEBOUNCE consecutive cycles; any shorter disagreement restarts the count.
REQ-013 A press event SHALL be one cycle, high on the cycle the debounced level goes 0->1; releases generate no event.
REQ-014 Raw-to-event latency SHALL be exactly 2+DEBOUNCE cycles for a clean edge; a held button SHALL yield exactly one event.
REQ-015 FSM transitions, start event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 FSM transition, clear event: any state->IDLE, with cnt_rst high for exactly the cycle after the event.
REQ-017 Start and clear events in the same cycle: clear SHALL win; start is discarded.
REQ-018 Prescaler: a counter 0..TICK_DIV-1 SHALL increment only in RUN and wrap to 0; cnt_en SHALL be high for the one cycle in which the prescaler value is TICK_DIV-1 while in RUN.
REQ-019 In PAUSE the prescaler SHALL hold its value so resume continues the partial period; on IDLE->RUN and on clear it SHALL be 0.
REQ-020 A transition RUN->PAUSE in the cycle the prescaler is at TICK_DIV-1 SHALL still issue that cnt_en pulse; no pulse is issued in PAUSE or IDLE.
REQ-021 cnt_en and cnt_rst SHALL never be high in the same cycle.
REQ-022 All outputs SHALL be registered; state encodings 11 SHALL recover to IDLE on the next cycle.

Reset
REQ-023 While rst is high, at every clock edge: state=IDLE, cnt_en=0, run_led=0, synchronizers, debounce counters, debounced levels and prescaler cleared to 0.
REQ-024 While rst is high, cnt_rst SHALL be 1, so the downstream counter clears together with the controller; it SHALL drop to 0 on the first edge after rst falls.
REQ-025 A button held high through reset release SHALL produce a press event after 2+DEBOUNCE cycles (debounced level restarts at 0).
REQ-026 Reset mid-RUN SHALL abandon the partial tick period; no cnt_en pulse in the reset cycle.

Verification (bench parameters DEBOUNCE=4, TICK_DIV=10)
REQ-027 rst=1 for 5 cycles, then 0 -> state=00, cnt_en=0, cnt_rst=1 during reset and 0 afterward.
REQ-028 btn_start high for 3 cycles, then a 20-cycle press -> the glitch gives no state change; the press gives IDLE->RUN 6 cycles after its rise; cnt_en pulses every 10 cycles, with the first pulse 10 cycles after entering RUN.
REQ-029 From RUN, press start 3 cycles after a cnt_en, stay in PAUSE 50 cycles, then press start again -> no cnt_en during PAUSE; the first pulse after resume comes 7 cycles after re-entering RUN.
REQ-030 Press btn_start and btn_clear on the same cycle while in RUN -> state=IDLE, one cnt_rst pulse, prescaler 0, no RUN->PAUSE.
REQ-031 Assert rst mid-RUN with the prescaler at 8 -> no cnt_en; after release state=IDLE; a new start gives a first tick a full 10 cycles after entering RUN.
REQ-032 Hold btn_start high for 200 cycles -> exactly one transition; the release produces no event.
